// File: rtl/spy_path_prober_if.sv
// Run request and result readout between the host side and the spy path prober.
// The host drives the request and result_ready; the prober drives the counts and result_valid.
interface spy_path_prober_if #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 4
);
  logic             start;
  logic [CNT_W-1:0] trials;
  logic [DLY_W-1:0] sample_delay;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] trial_count;

  modport master (
    output start, trials, sample_delay, result_ready,
    input  result_valid, err_count, trial_count
  );

  modport slave (
    input  start, trials, sample_delay, result_ready,
    output result_valid, err_count, trial_count
  );
endinterface

// File: rtl/spy_path_prober.sv
// Launches transitions into a spy delay chain, samples its output D edges later and
// counts late arrivals over a programmed number of trials.
module spy_path_prober #(
  parameter int CNT_W         = 16,
  parameter int DLY_W         = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int INVERT        = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  spy_path_prober_if.slave  ctrl,
  output logic              busy,
  output logic              chain_in,
  input  logic              chain_out
);

  localparam int              SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic            INV_BIT = (INVERT != 0);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, CHECK, SETTLE, REPORT
  } stateT;

  stateT            stateReg;
  logic [CNT_W-1:0] trialsReg;
  logic [CNT_W-1:0] errCountReg;
  logic [CNT_W-1:0] trialCountReg;
  logic [DLY_W-1:0] delayReg;
  logic [DLY_W-1:0] waitCntReg;
  logic [SET_W-1:0] settleCntReg;
  logic             chainInReg;
  logic             sampleReg;
  logic             syncReg;
  logic             pendingReg;
  logic             busyReg;
  logic             resultValidReg;

  logic [CNT_W-1:0] trialInc;
  logic [CNT_W-1:0] errInc;
  logic [CNT_W-1:0] trialsDone;
  logic             mismatch;

  assign trialInc   = (trialCountReg == CNT_MAX) ? trialCountReg : trialCountReg + 1'b1;
  assign errInc     = (errCountReg == CNT_MAX) ? errCountReg : errCountReg + 1'b1;
  // chainInReg still holds the launched level, so expected = chainInReg ^ INVERT
  assign mismatch   = syncReg ^ chainInReg ^ INV_BIT;
  assign trialsDone = pendingReg ? trialInc : trialCountReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg       <= IDLE;
      trialsReg      <= '0;
      errCountReg    <= '0;
      trialCountReg  <= '0;
      delayReg       <= '0;
      waitCntReg     <= '0;
      settleCntReg   <= '0;
      chainInReg     <= 1'b0;
      sampleReg      <= 1'b0;
      syncReg        <= 1'b0;
      pendingReg     <= 1'b0;
      busyReg        <= 1'b0;
      resultValidReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (ctrl.start) begin
            trialsReg     <= ctrl.trials;
            delayReg      <= (ctrl.sample_delay == '0) ? DLY_W'(1) : ctrl.sample_delay;
            errCountReg   <= '0;
            trialCountReg <= '0;
            busyReg       <= 1'b1;
            if (ctrl.trials == '0) begin
              stateReg       <= REPORT;
              resultValidReg <= 1'b1;
            end else begin
              stateReg <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          chainInReg <= ~chainInReg;
          waitCntReg <= delayReg;
          stateReg   <= WAIT;
        end
        WAIT: begin
          // The only capture of the raw chain output; it fires on edge E0+D.
          if (waitCntReg <= DLY_W'(1)) begin
            sampleReg <= chain_out;
            stateReg  <= CHECK;
          end else begin
            waitCntReg <= waitCntReg - 1'b1;
          end
        end
        CHECK: begin
          syncReg      <= sampleReg;
          pendingReg   <= 1'b1;
          settleCntReg <= SET_W'(SETTLE_CYCLES);
          stateReg     <= SETTLE;
        end
        SETTLE: begin
          // Counts are folded in on the first settle edge, once the resync flop is stable.
          if (pendingReg) begin
            pendingReg    <= 1'b0;
            trialCountReg <= trialInc;
            if (mismatch) errCountReg <= errInc;
          end
          if (settleCntReg <= SET_W'(1)) begin
            if (trialsDone == trialsReg) begin
              stateReg       <= REPORT;
              resultValidReg <= 1'b1;
            end else begin
              stateReg <= LAUNCH;
            end
          end else begin
            settleCntReg <= settleCntReg - 1'b1;
          end
        end
        REPORT: begin
          if (ctrl.result_ready) begin
            stateReg       <= IDLE;
            resultValidReg <= 1'b0;
            busyReg        <= 1'b0;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign busy              = busyReg;
  assign chain_in          = chainInReg;
  assign ctrl.result_valid = resultValidReg;
  assign ctrl.err_count    = errCountReg;
  assign ctrl.trial_count  = trialCountReg;

endmodule

// File: tb/tb_spy_path_prober.sv
// Bench for spy_path_prober: two instances (INVERT=0 and INVERT=1) each driving a
// delayed buffer/inverter chain model; table vectors, random runs and a reset abort.
`timescale 1ns/1ps
module tb_spy_path_prober;

  localparam int CNT_W  = 16;
  localparam int DLY_W  = 4;
  localparam int SETTLE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spy_path_prober_if #(.CNT_W(CNT_W), .DLY_W(DLY_W)) bus0 ();
  spy_path_prober_if #(.CNT_W(CNT_W), .DLY_W(DLY_W)) bus1 ();

  logic busy0, busy1, chainIn0, chainIn1;
  logic chainOut0 = 1'b0;
  logic chainOut1 = 1'b1;
  int   dly0 = 3;
  int   dly1 = 3;
  logic inv0 = 1'b0;
  logic inv1 = 1'b1;

  spy_path_prober #(.CNT_W(CNT_W), .DLY_W(DLY_W), .SETTLE_CYCLES(SETTLE), .INVERT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ctrl(bus0), .busy(busy0),
    .chain_in(chainIn0), .chain_out(chainOut0)
  );

  spy_path_prober #(.CNT_W(CNT_W), .DLY_W(DLY_W), .SETTLE_CYCLES(SETTLE), .INVERT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctrl(bus1), .busy(busy1),
    .chain_in(chainIn1), .chain_out(chainOut1)
  );

  // Chain models: transport delay of dlyN ns, optional inversion.
  always @(chainIn0 or inv0) chainOut0 <= #(dly0) (chainIn0 ^ inv0);
  always @(chainIn1 or inv1) chainOut1 <= #(dly1) (chainIn1 ^ inv1);

  int   checks = 0;
  int   failures = 0;
  logic modelLevel [2];

  typedef struct {
    int   which;
    int   t;
    int   d;
    int   dly;
    logic inv;
    int   hold;
    int   expErr;
    int   expTrials;
  } vecT;

  vecT vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic getValid(input int which);
    return (which == 1) ? bus1.result_valid : bus0.result_valid;
  endfunction
  function automatic logic getBusy(input int which);
    return (which == 1) ? busy1 : busy0;
  endfunction
  function automatic logic getChainIn(input int which);
    return (which == 1) ? chainIn1 : chainIn0;
  endfunction
  function automatic int getErr(input int which);
    return (which == 1) ? int'(bus1.err_count) : int'(bus0.err_count);
  endfunction
  function automatic int getTrials(input int which);
    return (which == 1) ? int'(bus1.trial_count) : int'(bus0.trial_count);
  endfunction

  task automatic setStart(input int which, input logic v, input int t, input int d);
    if (which == 1) begin
      bus1.start = v; bus1.trials = CNT_W'(t); bus1.sample_delay = DLY_W'(d);
    end else begin
      bus0.start = v; bus0.trials = CNT_W'(t); bus0.sample_delay = DLY_W'(d);
    end
  endtask

  task automatic setReady(input int which, input logic v);
    if (which == 1) bus1.result_ready = v;
    else            bus0.result_ready = v;
  endtask

  // Every trial either sees the settled level or, if the arrival is after the
  // capture edge, the previous level; mismatch follows from that and the polarities.
  function automatic int predictErr(input int which, input int t, input int dEff,
                                    input int dlyNs, input logic inv);
    logic late;
    logic rtlInv;
    late   = (dlyNs > 10 * dEff);
    rtlInv = (which == 1);
    return (late ^ inv ^ rtlInv) ? t : 0;
  endfunction

  task automatic runCase(input int which, input int t, input int d, input int dlyNs,
                         input logic inv, input int hold, input int expErr,
                         input int expTrials, input string tag);
    int   dEff, lat, bound, toggles, unstable;
    logic prev;
    dEff = (d == 0) ? 1 : d;
    if (which == 1) begin dly1 = dlyNs; inv1 = inv; end
    else            begin dly0 = dlyNs; inv0 = inv; end
    repeat (10) @(negedge clk);
    check({tag, " start_level"}, int'(getChainIn(which)), int'(modelLevel[which]));
    prev = getChainIn(which);
    setStart(which, 1'b1, t, d);
    @(negedge clk);
    setStart(which, 1'b0, t, d);
    lat = 0;
    toggles = 0;
    bound = t * (10 + dEff) + 20;
    while (!getValid(which) && lat < bound) begin
      @(negedge clk);
      lat++;
      if (getChainIn(which) != prev) begin
        toggles++;
        prev = getChainIn(which);
      end
    end
    check({tag, " latency"}, lat, t * (2 + dEff + SETTLE));
    check({tag, " err_count"}, getErr(which), expErr);
    check({tag, " trial_count"}, getTrials(which), expTrials);
    check({tag, " toggles"}, toggles, t);
    check({tag, " busy_report"}, int'(getBusy(which)), 1);
    modelLevel[which] = modelLevel[which] ^ logic'(t[0]);
    check({tag, " end_level"}, int'(getChainIn(which)), int'(modelLevel[which]));
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      setStart(which, logic'(i[0]), 0, 1);
      @(negedge clk);
      if (!getValid(which) || !getBusy(which) || getErr(which) != expErr ||
          getTrials(which) != expTrials || getChainIn(which) != modelLevel[which])
        unstable++;
    end
    setStart(which, 1'b0, 0, 1);
    if (hold > 0) check({tag, " hold_stable"}, unstable, 0);
    setReady(which, 1'b1);
    setStart(which, 1'b1, 3, 1);
    @(negedge clk);
    setReady(which, 1'b0);
    setStart(which, 1'b0, 0, 1);
    check({tag, " valid_clear"}, int'(getValid(which)), 0);
    check({tag, " busy_clear"}, int'(getBusy(which)), 0);
    repeat (2) @(negedge clk);
    check({tag, " no_restart"}, int'(getBusy(which)), 0);
    $display("run %s: dut=%0d trials=%0d delay=%0d chain=%0dns inv=%0d -> err=%0d trials=%0d latency=%0d",
             tag, which, t, d, dlyNs, inv, getErr(which), getTrials(which), lat);
  endtask

  initial begin
    int   toggles, budget;
    logic prev;
    setStart(0, 1'b0, 0, 0);
    setStart(1, 1'b0, 0, 0);
    setReady(0, 1'b0);
    setReady(1, 1'b0);
    modelLevel[0] = 1'b0;
    modelLevel[1] = 1'b0;

    vecs[0] = '{0, 8, 1,  3, 1'b0,  0, 0, 8};
    vecs[1] = '{0, 5, 2, 25, 1'b0,  0, 5, 5};
    vecs[2] = '{0, 5, 3, 25, 1'b0,  0, 0, 5};
    vecs[3] = '{1, 4, 1,  3, 1'b1,  0, 0, 4};
    vecs[4] = '{0, 4, 1,  3, 1'b1,  0, 4, 4};
    vecs[5] = '{0, 0, 1,  3, 1'b0,  0, 0, 0};
    vecs[6] = '{0, 2, 1,  3, 1'b0, 20, 0, 2};
    vecs[7] = '{0, 3, 0, 13, 1'b0,  0, 3, 3};
    vecs[8] = '{1, 3, 0,  7, 1'b1,  0, 0, 3};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy0), 0);
    check("reset valid", int'(bus0.result_valid), 0);
    check("reset chain_in", int'(chainIn0), 0);
    check("reset err_count", int'(bus0.err_count), 0);
    check("reset trial_count", int'(bus0.trial_count), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      runCase(vecs[i].which, vecs[i].t, vecs[i].d, vecs[i].dly, vecs[i].inv,
              vecs[i].hold, vecs[i].expErr, vecs[i].expTrials, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      int   w, t, d, dl, dEff;
      logic inv;
      w    = int'($urandom_range(0, 1));
      t    = int'($urandom_range(0, 6));
      d    = int'($urandom_range(0, 5));
      dl   = 10 * int'($urandom_range(0, 5)) + (($urandom_range(0, 1) == 1) ? 3 : 7);
      inv  = logic'($urandom_range(0, 1));
      dEff = (d == 0) ? 1 : d;
      runCase(w, t, d, dl, inv, 0, predictErr(w, t, dEff, dl, inv), t, $sformatf("rnd%0d", i));
    end

    // Abort during WAIT of the third trial.
    dly0 = 3; inv0 = 1'b0;
    repeat (10) @(negedge clk);
    setStart(0, 1'b1, 5, 3);
    @(negedge clk);
    setStart(0, 1'b0, 5, 3);
    toggles = 0;
    budget  = 0;
    prev    = chainIn0;
    while (toggles < 3 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (chainIn0 != prev) begin toggles++; prev = chainIn0; end
    end
    check("abort reach trial3", toggles, 3);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy0), 0);
    check("abort valid", int'(bus0.result_valid), 0);
    check("abort chain_in", int'(chainIn0), 0);
    check("abort err_count", int'(bus0.err_count), 0);
    check("abort trial_count", int'(bus0.trial_count), 0);
    $display("run abort: dut=0 reset asserted after %0d launches", toggles);
    modelLevel[0] = 1'b0;
    modelLevel[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runCase(0, 2, 1, 3, 1'b0, 0, 0, 2, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spy_path_prober.md
Name: spy_path_prober

Overview:
Measurement end of a chained spy delay path.
- Launches a transition into the chain input and samples the chain output a programmable number of clock cycles later.
- Compares the sample against the expected settled level and accumulates late-arrival (error) counts over a programmed number of trials.
- Reports the counts with a valid/ready handshake. It sits between the chained spy path and the host/UART readout logic.

Parameters:
CNT_W, 16, width of the trial and error counters
DLY_W, 4, width of the sample_delay input
SETTLE_CYCLES, 8, idle cycles after each capture before the next launch (must be >= 1)
INVERT, 0, 1 if the chain's net function is inversion (odd NOT count); expected = chain_in ^ INVERT

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; sampled only in IDLE
trials  in  CNT_W  number of launch/capture trials; latched at start
sample_delay  in  DLY_W  launch-to-capture distance in clock edges; latched at start; 0 is treated as 1
busy  out  1  high in every state except IDLE
chain_in  out  1  registered drive to the chain input (pathInput)
chain_out  in  1  chain output (pathResult); asynchronous to the launch timing by design
result_valid  out  1  counts available
result_ready  in  1  consumer accepts counts
err_count  out  CNT_W  trials whose capture mismatched the expected level
trial_count  out  CNT_W  trials actually executed

Behaviour:
- Reset (async, rst_n=0): state=IDLE; chain_in=0; busy=0; result_valid=0; err_count=0; trial_count=0; all internal counters and the sample flop cleared. Asserting reset mid-run aborts immediately; no partial result is reported.
- States: IDLE, LAUNCH, WAIT, CHECK, SETTLE, REPORT.
- IDLE:
  - start=1 latches trials (T) and sample_delay (D, forced to 1 if 0), and clears err_count/trial_count.
  - If T==0, go to REPORT; else go to LAUNCH.
  - start in any other state is ignored.
- LAUNCH (1 cycle):
  - chain_in toggles at the exit edge. This is launch edge E0.
  - expected = new chain_in ^ INVERT.
  - Wait counter loaded with D. Go to WAIT.
- WAIT:
  - Wait counter decrements each edge.
  - The sample flop is enabled on exactly edge E0+D and captures chain_out raw. This flop is the sensor: no synchronizer precedes it.
  - Then go to CHECK.
- CHECK (1 cycle):
  - A second flop resynchronizes the sample.
  - Mismatch vs expected increments err_count; trial_count increments unconditionally. Both saturate at 2^CNT_W-1.
  - Go to SETTLE.
- SETTLE:
  - Holds chain_in for SETTLE_CYCLES cycles.
  - When trial_count==T, go to REPORT; else go to LAUNCH.
- REPORT:
  - result_valid=1; err_count/trial_count stable.
  - On result_valid && result_ready, go to IDLE next edge and clear result_valid. busy stays 1 until then.
- Trial timing: cycles per trial = 1 + D + 1 + SETTLE_CYCLES.
- chain_in is never reset between trials, so successive trials alternate rising/falling launches. The first launch after reset is rising.
- Simultaneous start and result_ready in REPORT: start is ignored and a new run needs IDLE.
- Only the launch register and the sample flop touch the chain. The chain must never see a combinational path from FSM logic.

Test Plan:
- Chain model: buffer with 3 ns delay, clk 10 ns, INVERT=0, trials=8, D=1. Required: result_valid with err_count=0, trial_count=8; chain_in toggles 8 times, first toggle rising.
- Chain model with 25 ns delay, D=2 (20 ns window), trials=5. Required: err_count=5, trial_count=5; D=3 under the same model gives err_count=0.
- INVERT=1 with an inverting 3 ns model, trials=4, D=1. Required: err_count=0. The same model with INVERT=0 gives err_count=4.
- trials=0 start. Required: REPORT on the next cycle with err_count=0 and trial_count=0; chain_in never toggles.
- Hold result_ready=0 for 20 cycles in REPORT, pulsing start meanwhile. Required: outputs stable, no new run, IDLE one cycle after result_ready=1.
- Assert rst_n=0 during WAIT of trial 3. Required: busy, result_valid, chain_in and counts go to 0 immediately; a following run with trials=2 reports trial_count=2.
